cache_line_mem_bridge: RTL

- Sits directly downstream of the cache top-level, between its RAM-side port and a 32-bit word-wide memory bus.
- Converts each whole-line transfer into a burst of LINE_WORDS single-word accesses using a req/ack handshake.
  - Refill (read): assembles the returned words into one line.
  - Writeback (write): splits the dirty line into words.
- Signals completion to the cache controller with a one-cycle response pulse.

---
 rtl/cache_mem_pkg.sv | 18 +
 rtl/cache_line_mem_bridge_if.sv | 22 ++
 rtl/cache_line_buffer.sv | 55 +++++
 rtl/cache_line_mem_bridge.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared constants for the cache line <-> word memory bridge: word width,
// default line size, line offset derivation and FSM state encodings.
package cache_mem_pkg;

  localparam int WORD_W         = 32;
  localparam int DEF_LINE_WORDS = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_BURST = 2'd1;
  localparam logic [1:0] ST_WR_BURST = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Byte-offset bits covered by one line: word index bits plus 2 byte bits.
  function automatic int line_ofs(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/cache_line_mem_bridge_if.sv
// Word-wide memory bus with req/ack handshake; master drives the request side.
interface cache_line_mem_bridge_if;
  import cache_mem_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_line_buffer.sv
// One cache line held as LINE_WORDS word registers: full-line load, indexed
// word write, indexed word read and synchronous clear.
module cache_line_buffer
  import cache_mem_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              load_en,
  input  logic [WORD_W*LINE_WORDS-1:0]      load_line,
  input  logic                              wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0]     wr_idx,
  input  logic [WORD_W-1:0]                 wr_word,
  input  logic [$clog2(LINE_WORDS)-1:0]     rd_idx,
  output logic [WORD_W-1:0]                 rd_word,
  output logic [WORD_W*LINE_WORDS-1:0]      line_o
);

  localparam int IDX_W = $clog2(LINE_WORDS);

  logic [WORD_W-1:0] word_arr [LINE_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_q;
      logic [WORD_W-1:0] word_d;

      // A full-line load wins over a single-word write in the same cycle.
      always_comb begin
        word_d = word_q;
        if (load_en) begin
          word_d = load_line[gi*WORD_W +: WORD_W];
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          word_d = wr_word;
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign word_arr[gi]                   = word_q;
      assign line_o[gi*WORD_W +: WORD_W]    = word_q;
    end
  endgenerate

  assign rd_word = word_arr[rd_idx];

endmodule

// File: rtl/cache_line_mem_bridge.sv
// Turns whole-line refill/writeback requests from the cache into ascending
// bursts of single-word req/ack accesses, with an optional stall watchdog.
module cache_line_mem_bridge
  import cache_mem_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_cache_to_ram,
  input  logic                          write_cache_to_ram,
  input  logic [31:0]                   address_cache_to_ram,
  input  logic [WORD_W*LINE_WORDS-1:0]  data_cache_to_ram_i,
  output logic                          response_ram_to_cache,
  output logic [WORD_W*LINE_WORDS-1:0]  data_ram_to_cache_o,
  output logic                          bus_error,
  cache_line_mem_bridge_if.master       mem_bus
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFS    = line_ofs(LINE_WORDS);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [31:0]       OFS_MASK  = (32'd1 << OFS) - 32'd1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic              WDOG_EN   = (TIMEOUT != 0);

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic [CNT_W-1:0]  wait_q,  wait_d;
  logic [31:0]       base_q,  base_d;
  logic              we_q,    we_d;
  logic              err_q,   err_d;

  logic              buf_load;
  logic              buf_wr;
  logic [WORD_W-1:0] buf_rd_word;
  logic              in_burst;

  cache_line_buffer #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk       (clk),
    .clr       (rst),
    .load_en   (buf_load),
    .load_line (data_cache_to_ram_i),
    .wr_en     (buf_wr),
    .wr_idx    (beat_q),
    .wr_word   (mem_bus.mem_rdata),
    .rd_idx    (beat_q),
    .rd_word   (buf_rd_word),
    .line_o    (data_ram_to_cache_o)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    base_d   = base_q;
    we_d     = we_q;
    err_d    = err_q;
    buf_load = 1'b0;
    buf_wr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_cache_to_ram) begin
          base_d   = address_cache_to_ram & ~OFS_MASK;
          we_d     = write_cache_to_ram;
          beat_d   = '0;
          wait_d   = '0;
          err_d    = 1'b0;
          buf_load = write_cache_to_ram;
          state_d  = write_cache_to_ram ? ST_WR_BURST : ST_RD_BURST;
        end
      end

      ST_RD_BURST, ST_WR_BURST: begin
        if (mem_bus.mem_ack) begin
          buf_wr = ~we_q;
          wait_d = '0;
          // Beat stays parked on the last index so the counter never wraps.
          if (beat_q == BEAT_LAST) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          if (wait_q != '1) begin
            wait_d = wait_q + 1'b1;
          end
          if (WDOG_EN && (wait_q == WAIT_LAST)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      base_q  <= base_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs are pure functions of registered state, so they hold steady
  // through wait states until the accepting edge.
  assign in_burst          = (state_q == ST_RD_BURST) || (state_q == ST_WR_BURST);
  assign mem_bus.mem_req   = in_burst;
  assign mem_bus.mem_we    = in_burst && we_q;
  assign mem_bus.mem_addr  = in_burst ? (base_q | 32'({beat_q, 2'b00})) : '0;
  assign mem_bus.mem_wdata = (in_burst && we_q) ? buf_rd_word : '0;

  assign response_ram_to_cache = (state_q == ST_DONE);
  assign bus_error             = (state_q == ST_DONE) && err_q;

endmodule
